// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: key codes, debounce FSM
// encoding, the output bundle and the position/key decode helpers.
package keypad_pkg;

  typedef enum logic [3:0] {
    KEY_0     = 4'd0,
    KEY_1     = 4'd1,
    KEY_2     = 4'd2,
    KEY_3     = 4'd3,
    KEY_4     = 4'd4,
    KEY_5     = 4'd5,
    KEY_6     = 4'd6,
    KEY_7     = 4'd7,
    KEY_8     = 4'd8,
    KEY_9     = 4'd9,
    KEY_START = 4'd10,
    KEY_STOP  = 4'd11,
    KEY_CLEAR = 4'd12,
    KEY_NONE  = 4'd15
  } key_e;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED     = 2'd2;
  localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

  typedef struct packed {
    logic [9:0] kbd;
    logic       startn;
    logic       stopn;
    logic       clearn;
  } kp_out_t;

  localparam kp_out_t OUT_IDLE = '{kbd: '0, startn: 1'b1, stopn: 1'b1, clearn: 1'b1};

  // Matrix position (row*4 + col) to key; holes in the matrix read as no key.
  function automatic key_e pos_to_key(input logic [3:0] pos);
    case (pos)
      4'd0:    return KEY_1;
      4'd1:    return KEY_2;
      4'd2:    return KEY_3;
      4'd3:    return KEY_START;
      4'd4:    return KEY_4;
      4'd5:    return KEY_5;
      4'd6:    return KEY_6;
      4'd7:    return KEY_STOP;
      4'd8:    return KEY_7;
      4'd9:    return KEY_8;
      4'd10:   return KEY_9;
      4'd11:   return KEY_CLEAR;
      4'd13:   return KEY_0;
      default: return KEY_NONE;
    endcase
  endfunction

  function automatic kp_out_t key_to_out(input key_e key);
    kp_out_t o;
    o = OUT_IDLE;
    case (key)
      KEY_START: o.startn = 1'b0;
      KEY_STOP:  o.stopn  = 1'b0;
      KEY_CLEAR: o.clearn = 1'b0;
      default:   if (key <= KEY_9) o.kbd = 10'b1 << key;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-level debounce FSM: turns one frame result per scan into a committed
// key (level while pressed) plus a one-cycle pulse when a press is committed.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_stb,
  input  logic [3:0] frame_key,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_press
);

  localparam int              CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit              ONE_FRAME = (DEBOUNCE_FRAMES <= 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  key_e             cand_q, cand_d, fk;
  logic             press_q, press_d;

  assign fk      = key_e'(frame_key);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    press_d = 1'b0;
    if (frame_stb) begin
      case (state_q)
        ST_IDLE: if (fk != KEY_NONE) begin
          cand_d = fk;
          if (ONE_FRAME) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            state_d = ST_DEB_PRESS;
            cnt_d   = CNT_ONE;
          end
        end
        ST_DEB_PRESS: if (fk == cand_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        // Any other result (none, multi, another key) starts release counting.
        ST_PRESSED: if (fk != cand_q) begin
          state_d = ONE_FRAME ? ST_IDLE : ST_DEB_RELEASE;
          cnt_d   = ONE_FRAME ? '0 : CNT_ONE;
        end
        default: if (fk == cand_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_NONE;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      press_q <= press_d;
    end
  end

  assign key       = cand_q;
  assign key_valid = (state_q == ST_PRESSED) || (state_q == ST_DEB_RELEASE);
  assign key_press = press_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column synchronizer, row scan, per-frame evaluation and
// registered microwave-side outputs. Define KBD_ONESHOT_EN for one-cycle press pulses.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] kbd,
  output logic       startn,
  output logic       stopn,
  output logic       clearn
);

`ifdef KBD_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       col_meta_q, col_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d, row_cnt;
  logic [2:0]       sum_cnt;
  key_e             acc_key_q, acc_key_d, row_key, sum_key, pk;
  logic             frame_stb_q, frame_stb_d;
  key_e             frame_key_q, frame_key_d;
  kp_out_t          out_q, out_d;
  logic             slot_end;
  logic [3:0]       db_key;
  logic             db_valid, db_press;

  assign slot_end = (div_q == DIV_LAST);

  // NOTE: every variable gets a default at the top of always_comb, so no path leaves one unassigned (no latch).
  always_comb begin
    div_d       = slot_end ? '0 : div_q + DIV_W'(1);
    row_d       = slot_end ? row_q + 2'd1 : row_q;
    row_cnt     = '0;
    row_key     = KEY_NONE;
    pk          = KEY_NONE;
    for (int c = 0; c < 4; c++) begin
      pk = pos_to_key({row_q, 2'(c)});
      if (!col_sync_q[c] && pk != KEY_NONE) begin
        if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
        row_key = pk;
      end
    end
    sum_cnt     = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
    if (sum_cnt > 3'd2) sum_cnt = 3'd2;
    sum_key     = (row_cnt != 2'd0) ? row_key : acc_key_q;
    acc_cnt_d   = acc_cnt_q;
    acc_key_d   = acc_key_q;
    frame_stb_d = 1'b0;
    frame_key_d = frame_key_q;
    if (slot_end) begin
      if (row_q == 2'd3) begin
        // Two or more keys in a frame are reported as no key.
        frame_stb_d = 1'b1;
        frame_key_d = (sum_cnt == 3'd1) ? sum_key : KEY_NONE;
        acc_cnt_d   = '0;
        acc_key_d   = KEY_NONE;
      end else begin
        acc_cnt_d   = sum_cnt[1:0];
        acc_key_d   = sum_key;
      end
    end
    out_d = (ONESHOT ? db_press : db_valid) ? key_to_out(key_e'(db_key)) : OUT_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      div_q       <= '0;
      row_q       <= '0;
      acc_cnt_q   <= '0;
      acc_key_q   <= KEY_NONE;
      frame_stb_q <= 1'b0;
      frame_key_q <= KEY_NONE;
      out_q       <= OUT_IDLE;
    end else begin
      col_meta_q  <= col_n;
      col_sync_q  <= col_meta_q;
      div_q       <= div_d;
      row_q       <= row_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_key_q   <= acc_key_d;
      frame_stb_q <= frame_stb_d;
      frame_key_q <= frame_key_d;
      out_q       <= out_d;
    end
  end

  key_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk       (clk),
    .resetn    (resetn),
    .frame_stb (frame_stb_q),
    .frame_key (frame_key_q),
    .key       (db_key),
    .key_valid (db_valid),
    .key_press (db_press)
  );

  assign row_n  = ~(4'b0001 << row_q);
  assign kbd    = out_q.kbd;
  assign startn = out_q.startn;
  assign stopn  = out_q.stopn;
  assign clearn = out_q.clearn;

endmodule
